// File: rtl/ref_seq_streamer_if.sv
// ref_seq_streamer_if: memory read port plus DTW input stream as seen by
// the streamer (master) and by the memory/DTW core side (slave).
interface ref_seq_streamer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_CS;
    logic              mem_WR;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] dtw_in;
    logic              dtw_valid;
    logic              dtw_ready;

    modport master (
        output mem_addr, mem_CS, mem_WR, dtw_in, dtw_valid,
        input  mem_rdata, dtw_ready
    );

    modport slave (
        input  mem_addr, mem_CS, mem_WR, dtw_in, dtw_valid,
        output mem_rdata, dtw_ready
    );
endinterface

// File: rtl/ref_seq_streamer.sv
// ref_seq_streamer: reads num_seq sequences of SEQ_LEN words from a shared
// single-port memory and forwards each one to the DTW core as a single
// gap-free dtw_valid burst, waiting for dtw_ready between sequences.
module ref_seq_streamer #(
    parameter int SEQ_LEN = 20,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_seq,
    output logic              busy,
    output logic              done,
    ref_seq_streamer_if.master bus
);
    localparam int               CNT_W     = $clog2(SEQ_LEN);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              drain_q, drain_d;
    logic [7:0]        remain_q, remain_d;
    logic              cs_q, cs_d;
    logic              rd1_q, rd1_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: READ lasts SEQ_LEN cycles, DRAIN two, WAIT until ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (num_seq == '0) ? S_DONE : S_READ;
            S_READ:  if (word_cnt_q == LAST_WORD) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_WAIT;
            S_WAIT:  if (bus.dtw_ready) state_d = (remain_q <= 8'd1) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; chip select follows the next state so
    // it is low exactly while READ is the registered state.
    always_comb begin
        ptr_d      = ptr_q;
        word_cnt_d = '0;
        drain_d    = 1'b0;
        remain_d   = remain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d    = base_addr;
                    remain_d = num_seq;
                end
            end
            S_READ: begin
                ptr_d      = ptr_q + ADDR_W'(1);
                word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + CNT_W'(1);
            end
            S_DRAIN: drain_d = ~drain_q;
            S_WAIT: begin
                if (bus.dtw_ready && (remain_q != '0)) remain_d = remain_q - 8'd1;
            end
            default: begin
            end
        endcase
        cs_d    = (state_d != S_READ);
        // Stage 1 marks a read sampled by the memory, stage 2 is the beat.
        rd1_d   = ~cs_q;
        valid_d = rd1_q;
        data_d  = rd1_q ? bus.mem_rdata : '0;
        // busy stays up through the DONE cycle and the one after it.
        busy_d  = (state_d != S_IDLE) || (state_q == S_DONE);
        done_d  = (state_q == S_DONE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q      <= '0;
            word_cnt_q <= '0;
            drain_q    <= 1'b0;
            remain_q   <= '0;
            cs_q       <= 1'b1;
            rd1_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            word_cnt_q <= word_cnt_d;
            drain_q    <= drain_d;
            remain_q   <= remain_d;
            cs_q       <= cs_d;
            rd1_q      <= rd1_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_addr  = ptr_q;
    assign bus.mem_CS    = cs_q;
    assign bus.mem_WR    = 1'b0;
    assign bus.dtw_in    = data_q;
    assign bus.dtw_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_ref_seq_streamer.sv
// tb_ref_seq_streamer: table of streaming jobs run through one checker task,
// plus hand-written back-to-back start and mid-burst reset sequences.
module tb_ref_seq_streamer;
    localparam int SEQ_LEN = 20;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [7:0]        nseq;
        int                gap;          // cycles from last beat to ready pulse
        bit                hold_ready;   // ready high during first READ/DRAIN
        bit                stray_start;  // start pulses while busy
        int                exp_bursts;
        int                exp_beats;
        int                exp_done_lat; // cycles from final command to done
    } job_t;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [7:0]        num_seq = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    ref_seq_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ref_seq_streamer #(.SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .base_addr (base_addr),
        .num_seq   (num_seq),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Single-port memory: read sampled on the edge, data valid next cycle.
    always @(posedge clk) begin
        if (!bus.mem_CS) bus.mem_rdata <= mem[bus.mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_cs"},    bus.mem_CS, 1);
        check({tag, "_wr"},    bus.mem_WR, 0);
        check({tag, "_addr"},  bus.mem_addr, 0);
        check({tag, "_valid"}, bus.dtw_valid, 0);
        check({tag, "_din"},   bus.dtw_in, 0);
    endtask

    // Issues one job and checks every cycle of it until busy drops after done.
    // t = 0 is the first negedge after the edge that samples start.
    task automatic run_job(input job_t j, input string tag);
        int t, s_cs, cs_k, beat_k, bursts, total_cs, total_beats;
        int exp_cs_start, cs_start, ready_t, stray_t2, last_cmd_t, done_t, done_cnt;
        int gap_err, idle_data_err, limit, exp_a;
        bit holding;
        t = 0; s_cs = 0; cs_k = 0; beat_k = 0; bursts = 0; total_cs = 0; total_beats = 0;
        exp_cs_start = 0; cs_start = 0; ready_t = -1; stray_t2 = -1; last_cmd_t = -1;
        done_t = -1; done_cnt = 0; gap_err = 0; idle_data_err = 0;
        holding = j.hold_ready;
        limit = (int'(j.nseq) + 1) * (SEQ_LEN + j.gap + 10) + 20;

        @(negedge clk);
        start = 1'b1; base_addr = j.base; num_seq = j.nseq;
        bus.dtw_ready = holding;
        @(negedge clk);
        while (t < limit) begin
            if (t == 0) check({tag, "_busy_t0"}, busy, 1);
            if (!bus.mem_CS) begin
                exp_a = (int'(j.base) + s_cs * SEQ_LEN + cs_k) % 1024;
                check({tag, "_addr"}, bus.mem_addr, exp_a);
                if (cs_k == 0) begin
                    check({tag, "_cs_start"}, t, exp_cs_start);
                    cs_start = t;
                end
                cs_k++; total_cs++;
                if (cs_k == SEQ_LEN) begin cs_k = 0; s_cs++; end
            end
            if (bus.dtw_valid) begin
                check({tag, "_data"}, bus.dtw_in, 32'h100 + (int'(j.base) + total_beats) % 1024);
                if (beat_k == 0) check({tag, "_beat_lat"}, t, cs_start + 2);
                beat_k++; total_beats++;
                if (beat_k == SEQ_LEN) begin
                    beat_k = 0; bursts++;
                    ready_t = t + j.gap;
                    if (stray_t2 < 0) stray_t2 = t + 10;
                    holding = 1'b0;
                end
            end else begin
                if (beat_k != 0) gap_err++;
                if (bus.dtw_in != '0) idle_data_err++;
            end
            if (done) begin
                done_cnt++; done_t = t;
                check({tag, "_done_t"}, t, last_cmd_t + j.exp_done_lat);
            end
            if (done_t >= 0 && t == done_t + 1) begin
                check({tag, "_busy_end"}, busy, 0);
                break;
            end
            if (t == ready_t) begin
                bus.dtw_ready = 1'b1; last_cmd_t = t; exp_cs_start = t + 1;
            end else begin
                bus.dtw_ready = holding;
            end
            start = j.stray_start && (t == 5 || t == stray_t2);
            if (start) begin base_addr = '1; num_seq = 8'd9; end
            t++;
            @(negedge clk);
        end
        start = 1'b0; bus.dtw_ready = 1'b0;
        check({tag, "_timeout"}, (done_t >= 0), 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_bursts"}, bursts, j.exp_bursts);
        check({tag, "_beats"}, total_beats, j.exp_beats);
        check({tag, "_cs_cycles"}, total_cs, j.exp_beats);
        check({tag, "_gaps"}, gap_err, 0);
        check({tag, "_idle_din"}, idle_data_err, 0);
        check({tag, "_wr"}, bus.mem_WR, 0);
    endtask

    initial begin
        job_t jobs[6];
        job_t after_rst;
        int got, n_beats, ready_at;
        bit seen_done;

        jobs[0] = '{base: 10'd0,    nseq: 8'd1,  gap: 5,  hold_ready: 1'b0, stray_start: 1'b0,
                    exp_bursts: 1,  exp_beats: 20,  exp_done_lat: 2};
        jobs[1] = '{base: 10'd20,   nseq: 8'd10, gap: 3,  hold_ready: 1'b0, stray_start: 1'b0,
                    exp_bursts: 10, exp_beats: 200, exp_done_lat: 2};
        jobs[2] = '{base: 10'd1014, nseq: 8'd1,  gap: 5,  hold_ready: 1'b0, stray_start: 1'b0,
                    exp_bursts: 1,  exp_beats: 20,  exp_done_lat: 2};
        jobs[3] = '{base: 10'd5,    nseq: 8'd0,  gap: 2,  hold_ready: 1'b0, stray_start: 1'b0,
                    exp_bursts: 0,  exp_beats: 0,   exp_done_lat: 2};
        jobs[4] = '{base: 10'd100,  nseq: 8'd2,  gap: 50, hold_ready: 1'b1, stray_start: 1'b1,
                    exp_bursts: 2,  exp_beats: 40,  exp_done_lat: 2};
        jobs[5] = '{base: 10'd1000, nseq: 8'd3,  gap: 1,  hold_ready: 1'b0, stray_start: 1'b0,
                    exp_bursts: 3,  exp_beats: 60,  exp_done_lat: 2};
        after_rst = '{base: 10'd600, nseq: 8'd1, gap: 3, hold_ready: 1'b0, stray_start: 1'b0,
                      exp_bursts: 1, exp_beats: 20, exp_done_lat: 2};

        for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;
        bus.dtw_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset("por");
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            run_job(jobs[k], $sformatf("job%0d", k));
            repeat (3) @(negedge clk);
        end

        // Back-to-back: start accepted in the IDLE cycle right after DONE.
        @(negedge clk);
        start = 1'b1; base_addr = '0; num_seq = 8'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("b2b_done", done, 1);
        start = 1'b1; base_addr = 10'd50; num_seq = 8'd1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_cs", bus.mem_CS, 0);
        check("b2b_addr", bus.mem_addr, 50);
        check("b2b_busy", busy, 1);
        got = 0; seen_done = 1'b0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            @(negedge clk);
            bus.dtw_ready = 1'b0;
            if (bus.dtw_valid) got++;
            if (done) seen_done = 1'b1;
            else if (got == SEQ_LEN && !bus.dtw_valid) bus.dtw_ready = 1'b1;
        end
        bus.dtw_ready = 1'b0;
        check("b2b_beats", got, SEQ_LEN);
        check("b2b_seen_done", seen_done, 1);
        repeat (3) @(negedge clk);

        // Reset after beat 7 of sequence 2, then a fresh job from a new base.
        @(negedge clk);
        start = 1'b1; base_addr = 10'd300; num_seq = 8'd3;
        @(negedge clk);
        start = 1'b0;
        n_beats = 0; ready_at = -1;
        for (int c = 0; c < 600; c++) begin
            if (bus.dtw_valid) begin
                n_beats++;
                if (n_beats % SEQ_LEN == 0) ready_at = c + 2;
            end
            if (n_beats == 2 * SEQ_LEN + 8) break;
            bus.dtw_ready = (c == ready_at);
            @(negedge clk);
        end
        bus.dtw_ready = 1'b0;
        check("rst_beats_seen", n_beats, 2 * SEQ_LEN + 8);
        check("rst_pre_valid", bus.dtw_valid, 1);
        nrst = 1'b0;
        #1;
        check_reset("midrst");
        repeat (2) @(negedge clk);
        check_reset("midrst_hold");
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_idle_busy", busy, 0);
        check("rst_idle_cs", bus.mem_CS, 1);
        run_job(after_rst, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
